// File: rtl/candy_sram_pipe.sv
// ---------------------------------------------------------------------------
// candy_sram_pipe
//
// Single-clock simple-dual-port SRAM for the candy core memory subsystem:
// one write port with per-byte enables, one read port with a valid/ready
// request handshake, a configurable-latency read pipeline and a response FIFO.
// A credit counter limits accepted reads so that the FIFO can never overflow.
// Reads and writes are independent.
//
// Optional feature macro: CANDY_SRAM_BYPASS_EN
//   defined   -> a read accepted in the same cycle as a write to the same
//                address returns the write-merged word (write-first).
//   undefined -> the same case returns the pre-write contents (read-first).
//
// Ports
//   clk            in   clock, all logic on the rising edge
//   rst            in   synchronous active-low reset
//   wr_en          in   write strobe (always accepted)
//   wr_addr        in   write word address
//   wr_data        in   write data
//   wr_be          in   byte enables, bit i covers wr_data[8i+7:8i]
//   rd_req_valid   in   read request valid
//   rd_req_ready   out  read request can be accepted (credit available)
//   rd_addr        in   read word address, sampled on acceptance
//   rd_resp_valid  out  response FIFO head valid
//   rd_resp_ready  in   consumer takes the head this cycle
//   rd_resp_data   out  response FIFO head, 0 when the FIFO is empty
// ---------------------------------------------------------------------------
module candy_sram_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int RESP_DEPTH   = READ_LATENCY + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_resp_valid,
  input  logic                    rd_resp_ready,
  output logic [DATA_WIDTH-1:0]   rd_resp_data
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  // Elaboration-time parameter sanity checks.
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("candy_sram_pipe: DATA_WIDTH must be a multiple of 8");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("candy_sram_pipe: READ_LATENCY must be 1..4");
  end
  if (RESP_DEPTH < READ_LATENCY + 1) begin : g_bad_resp_depth
    $error("candy_sram_pipe: RESP_DEPTH must be >= READ_LATENCY+1");
  end

  // -------------------------------------------------------------------------
  // Memory array
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose: clearing thousands of
  // words is not possible in one cycle and would prevent RAM inference.
  // Contents are only defined once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Word seen by a read accepted this cycle. The array is sampled in the
  // acceptance cycle, so later writes never disturb a read in flight.
  logic [DATA_WIDTH-1:0] rd_word;

  // NOTE: every variable written in an always_comb gets a value at the top
  // of the block; a path that leaves it unassigned would infer a latch.
  always_comb begin
    rd_word = mem[rd_addr];
`ifdef CANDY_SRAM_BYPASS_EN
    // Write-first: merge the enabled bytes of a same-address write.
    if (wr_en && (wr_addr == rd_addr)) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Handshake and credits
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] credit_cnt;   // free slots: RESP_DEPTH - (fifo + in flight)
  logic [CNT_W-1:0] fifo_cnt;
  logic             accept;
  logic             pop;
  logic             push;
  logic [DATA_WIDTH-1:0] push_data;

  assign rd_req_ready  = (credit_cnt != '0);
  assign accept        = rd_req_valid && rd_req_ready;
  assign rd_resp_valid = (fifo_cnt != '0);
  assign pop           = rd_resp_valid && rd_resp_ready;

  // NOTE: registered state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_cnt <= CNT_FULL;
    end else if (accept && !pop) begin
      credit_cnt <= credit_cnt - CNT_ONE;
    end else if (!accept && pop) begin
      credit_cnt <= credit_cnt + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline: READ_LATENCY-1 register stages between the array sample
  // and the FIFO write, so data lands in the FIFO at the end of cycle
  // T+READ_LATENCY-1 for a request accepted in cycle T.
  // -------------------------------------------------------------------------
  if (READ_LATENCY == 1) begin : g_no_pipe
    assign push      = accept;
    assign push_data = rd_word;
  end else begin : g_pipe
    localparam int PIPE_N = READ_LATENCY - 1;

    logic [PIPE_N-1:0]     pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [PIPE_N];

    always_ff @(posedge clk) begin
      if (!rst) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= accept;
        for (int k = 1; k < PIPE_N; k++) begin
          pipe_valid[k] <= pipe_valid[k-1];
        end
      end
    end

    // Data stages are qualified by pipe_valid and need no reset.
    always_ff @(posedge clk) begin
      pipe_data[0] <= rd_word;
      for (int k = 1; k < PIPE_N; k++) begin
        pipe_data[k] <= pipe_data[k-1];
      end
    end

    assign push      = pipe_valid[PIPE_N-1];
    assign push_data = pipe_data[PIPE_N-1];
  end

  // -------------------------------------------------------------------------
  // Response FIFO: circular buffer, pointers wrap modulo RESP_DEPTH.
  // Credits guarantee a push never lands on an occupied slot, so the head
  // entry stays stable while the consumer stalls.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_ONE;
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_resp_data = rd_resp_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_candy_sram_pipe.sv
// ---------------------------------------------------------------------------
// tb_candy_sram_pipe
//
// Scoreboard bench for candy_sram_pipe (READ_LATENCY=2, RESP_DEPTH=3).
// The driver keeps a plain word-array model of the memory; whenever a read
// is accepted it pushes the expected word into a queue. An independent
// monitor pops and compares every response the DUT hands over.
// ---------------------------------------------------------------------------
module tb_candy_sram_pipe;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;
  localparam int RL = 2;
  localparam int RD = 3;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_be;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_resp_valid;
  logic          rd_resp_ready;
  logic [DW-1:0] rd_resp_data;

  candy_sram_pipe #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL),
    .RESP_DEPTH  (RD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_resp_data (rd_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
    bit            lat_chk;
    bit            tput;
    bit            tput_first;
  } exp_t;

  typedef struct {
    bit            wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    bit            rv;
    logic [AW-1:0] ra;
    bit            rr;
  } stim_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model [0:(1<<AW)-1];
  bit            last_acc;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  function automatic stim_t mk(input bit wv, input int wa, input logic [DW-1:0] wd,
                               input logic [BW-1:0] be, input bit rv, input int ra,
                               input bit rr);
    stim_t s;
    s.wv = wv;
    s.wa = AW'(wa);
    s.wd = wd;
    s.be = be;
    s.rv = rv;
    s.ra = AW'(ra);
    s.rr = rr;
    return s;
  endfunction

  // Drives one cycle (called just after a rising edge, returns just after
  // the next one). Expected data is taken from the model as it stands in the
  // acceptance cycle, or from fixed_val for directed cases.
  task automatic drive(input stim_t s,
                       input bit fixed = 1'b0, input logic [DW-1:0] fixed_val = '0,
                       input bit lat_chk = 1'b0, input bit tput = 1'b0,
                       input bit tput_first = 1'b0);
    exp_t e;
    wr_en         = s.wv;
    wr_addr       = s.wa;
    wr_data       = s.wd;
    wr_be         = s.be;
    rd_req_valid  = s.rv;
    rd_addr       = s.ra;
    rd_resp_ready = s.rr;
    last_acc = rst && s.rv && rd_req_ready;
    if (last_acc) begin
      if (fixed) begin
        e.data = fixed_val;
      end else begin
        e.data = model[s.ra];
`ifdef CANDY_SRAM_BYPASS_EN
        if (s.wv && (s.wa == s.ra)) e.data = merge(model[s.ra], s.wd, s.be);
`endif
      end
      e.acc_cyc    = cyc;
      e.lat_chk    = lat_chk;
      e.tput       = tput;
      e.tput_first = tput_first;
      sb_q.push_back(e);
    end
    if (s.wv) model[s.wa] = merge(model[s.wa], s.wd, s.be);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    repeat (n) drive(mk(0, 0, '0, '0, 0, 0, rr));
  endtask

  // Holds reset for n cycles; anything accepted earlier is discarded.
  task automatic do_reset(input int n, input bit rv);
    rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      drive(mk(0, 0, '0, '0, rv, $urandom_range(0, 31), 1'b0));
      check("reset_resp_valid", rd_resp_valid, 0);
      check("reset_resp_data", rd_resp_data, 0);
    end
    rst = 1'b1;
    check("ready_after_reset", rd_req_ready, 1);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 100;
    while ((sb_q.size() != 0 || rd_resp_valid) && budget > 0) begin
      idle(1, 1'b1);
      budget--;
    end
    check(name, sb_q.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor: pops the scoreboard whenever a response is handed over.
  // -------------------------------------------------------------------------
  bit            mon_held = 1'b0;
  logic [DW-1:0] mon_held_d;
  int            mon_prev_pop = -10;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_held = 1'b0;
        continue;
      end
      if (mon_held) begin
        check("stall_valid_held", rd_resp_valid, 1);
        check("stall_data_held", rd_resp_data, mon_held_d);
      end
      if (!rd_resp_valid) begin
        check("empty_data_zero", rd_resp_data, 0);
      end else if (rd_resp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_response", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("resp_data", rd_resp_data, e.data);
          if (e.lat_chk) check("resp_latency", cyc - e.acc_cyc, RL);
          if (e.tput && !e.tput_first) check("tput_consecutive", cyc, mon_prev_pop + 1);
          mon_prev_pop = cyc;
        end
      end
      mon_held   = rd_resp_valid && !rd_resp_ready;
      mon_held_d = rd_resp_data;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : stimulus
    int acc_n;
    int wa;
    int ra;

    rst           = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_be         = '0;
    rd_req_valid  = 1'b0;
    rd_addr       = '0;
    rd_resp_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with requests held high: nothing may come out of it.
    do_reset(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      check("post_reset_no_resp", rd_resp_valid, 0);
    end

    // Fill the addresses the bench reads from.
    for (int a = 0; a < 32; a++) drive(mk(1, a, $urandom, 4'hF, 0, 0, 1));

    // Byte-enable write and exact latency.
    drive(mk(1, 5, 32'h11223344, 4'hF, 0, 0, 1));
    drive(mk(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 1));
    drive(mk(0, 0, '0, '0, 1, 5, 1), 1'b1, 32'h11BB33DD, 1'b1);
    drain("drain_byte_write");
    // All byte enables cleared: no change.
    drive(mk(1, 5, 32'hFFFFFFFF, 4'h0, 0, 0, 1));
    drive(mk(0, 0, '0, '0, 1, 5, 1), 1'b1, 32'h11BB33DD);
    drain("drain_be_zero");

    // Same-cycle collision on address 7.
    drive(mk(1, 7, 32'h0, 4'hF, 0, 0, 1));
`ifdef CANDY_SRAM_BYPASS_EN
    drive(mk(1, 7, 32'hCAFEF00D, 4'hF, 1, 7, 1), 1'b1, 32'hCAFEF00D);
`else
    drive(mk(1, 7, 32'hCAFEF00D, 4'hF, 1, 7, 1), 1'b1, 32'h0);
`endif
    drive(mk(0, 0, '0, '0, 1, 7, 1), 1'b1, 32'hCAFEF00D);
    // Partial-byte collision, then a write landing behind a read in flight.
    drive(mk(1, 8, 32'h5A5A5A5A, 4'b0011, 1, 8, 1));
    drive(mk(0, 0, '0, '0, 1, 9, 1));
    drive(mk(1, 9, 32'h0BADBEEF, 4'hF, 0, 0, 1));
    drive(mk(0, 0, '0, '0, 1, 9, 1), 1'b1, 32'h0BADBEEF);
    drain("drain_collision");

    // Backpressure: consumer stalled, ten one-shot requests.
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(mk(0, 0, '0, '0, 1, i, 0));
      acc_n += int'(last_acc);
    end
    check("bp_accepted", acc_n, RD);
    check("bp_ready_low", rd_req_ready, 0);
    drain("drain_backpressure");

    // Throughput: 16 back-to-back reads, one response per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(mk(0, 0, '0, '0, 1, $urandom_range(0, 31), 1), 1'b0, '0, 1'b0, 1'b1, i == 0);
      check("tput_accept", last_acc, 1);
    end
    drain("drain_throughput");

    // Reset while two reads are in flight.
    drive(mk(0, 0, '0, '0, 1, 1, 0));
    check("midflight_acc0", last_acc, 1);
    drive(mk(0, 0, '0, '0, 1, 2, 0));
    check("midflight_acc1", last_acc, 1);
    do_reset(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      check("midflight_no_resp", rd_resp_valid, 0);
    end
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, '0, '0, 1, 10 + i, 0));
      acc_n += int'(last_acc);
    end
    check("credits_restored", acc_n, RD);
    drain("drain_midflight");

    // Randomized traffic with frequent address collisions.
    for (int i = 0; i < 1500; i++) begin
      wa = $urandom_range(0, 31);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      drive(mk($urandom_range(0, 1) == 1, wa, $urandom, BW'($urandom),
               $urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0));
    end
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
